// File: rtl/prbs8_pkg.sv
// Shared definitions for the PRBS8 checker: LFSR width, taps, checker state and a single LFSR step.
package prbs8_pkg;

    localparam int          LFSR_W    = 8;
    localparam logic [7:0]  LFSR_TAPS = 8'b0001_1101;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Shift right; the new MSB is the XOR of the tapped bits s[4], s[3], s[2], s[0].
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/prbs8_step_unroll.sv
// Combinational N-step unroll of the PRBS8 LFSR state update.
module prbs8_step_unroll
    import prbs8_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [LFSR_W-1:0] i_state,
    output logic [LFSR_W-1:0] o_state
);

    always_comb begin
        o_state = i_state;
        for (int k = 0; k < N; k++) begin
            o_state = lfsr_step(o_state);
        end
    end

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 receive checker: locks on 8 beats, then predicts and counts mismatches.
// Optional bit-error counter output err_bits is enabled by defining PRBS8_CHK_BITCNT_EN.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int DATA_W      = 2,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              locked,
    output logic              err_pulse,
    output logic              loss_pulse,
`ifdef PRBS8_CHK_BITCNT_EN
    output logic [CNT_W-1:0]  err_bits,
`endif
    output logic [CNT_W-1:0]  err_cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur, input logic [3:0] amt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (CNT_W+1)'(amt);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    state_t              r_state, w_state_nxt;
    // Only the 7 most recent bits are kept; the 8th comes straight from in_data.
    logic [7:1]          r_sr, w_sr_nxt;
    logic [2:0]          r_beat, w_beat_nxt;
    logic [3:0]          r_miss, w_miss_nxt;
    logic [LFSR_W-1:0]   r_exp, w_exp_nxt;
    logic                r_err_pulse, w_err_nxt;
    logic                r_loss_pulse, w_loss_nxt;
    logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;

    logic [LFSR_W-1:0]   w_seed, w_seed_adv, w_exp_step;
    logic [DATA_W-1:0]   w_diff;
    logic                w_mismatch;
    logic [3:0]          w_miss_inc;

    assign w_seed     = {in_data[0], r_sr};
    assign w_diff     = in_data ^ r_exp[DATA_W-1:0];
    assign w_mismatch = |w_diff;
    assign w_miss_inc = r_miss + 4'd1;

    prbs8_step_unroll #(.N(8)) u_seed_adv (.i_state(w_seed), .o_state(w_seed_adv));
    prbs8_step_unroll #(.N(1)) u_exp_step (.i_state(r_exp),  .o_state(w_exp_step));

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_beat_nxt  = r_beat;
        w_miss_nxt  = r_miss;
        w_exp_nxt   = r_exp;
        w_err_nxt   = 1'b0;
        w_loss_nxt  = 1'b0;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    w_sr_nxt   = w_seed[7:1];
                    w_beat_nxt = r_beat + 3'd1;
                    // A zero seed is the LFSR lockup value; keep collecting instead.
                    if (r_beat == 3'd7 && w_seed != '0) begin
                        w_state_nxt = LOCKED;
                        w_exp_nxt   = w_seed_adv;
                        w_miss_nxt  = '0;
                    end
                end
                LOCKED: begin
                    w_exp_nxt = w_exp_step;
                    if (w_mismatch) begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == 4'(LOSS_THRESH)) begin
                            w_loss_nxt  = 1'b1;
                            w_state_nxt = SEARCH;
                            w_beat_nxt  = '0;
                            w_sr_nxt    = '0;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_miss_nxt = '0;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
        if (clr) begin
            w_err_cnt_nxt = '0;
        end else if (w_err_nxt) begin
            w_err_cnt_nxt = sat_add(r_err_cnt, 4'd1);
        end else begin
            w_err_cnt_nxt = r_err_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SEARCH;
            r_sr         <= '0;
            r_beat       <= '0;
            r_miss       <= '0;
            r_exp        <= '0;
            r_err_pulse  <= 1'b0;
            r_loss_pulse <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_beat       <= w_beat_nxt;
            r_miss       <= w_miss_nxt;
            r_exp        <= w_exp_nxt;
            r_err_pulse  <= w_err_nxt;
            r_loss_pulse <= w_loss_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

`ifdef PRBS8_CHK_BITCNT_EN
    function automatic logic [3:0] popcount(input logic [DATA_W-1:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    logic [CNT_W-1:0] r_err_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_bits <= '0;
        end else if (clr) begin
            r_err_bits <= '0;
        end else if (w_err_nxt) begin
            r_err_bits <= sat_add(r_err_bits, popcount(w_diff));
        end
    end

    assign err_bits = r_err_bits;
`endif

    assign locked     = (r_state == LOCKED);
    assign err_pulse  = r_err_pulse;
    assign loss_pulse = r_loss_pulse;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_prbs8_checker.sv
// Randomised self-checking bench for prbs8_checker with a queue-based behavioural model.
module tb_prbs8_checker;

    localparam int DATA_W      = 2;
    localparam int LOSS_THRESH = 4;
    localparam int CNT_W       = 16;
    localparam int CNT_W_S     = 4;

    logic clk = 1'b0;
    logic rst, clr, in_valid;
    logic [DATA_W-1:0] in_data;

    logic locked0, errp0, lossp0;
    logic [CNT_W-1:0] cnt0;
    logic locked1, errp1, lossp1;
    logic [CNT_W_S-1:0] cnt1;
`ifdef PRBS8_CHK_BITCNT_EN
    logic [CNT_W-1:0]   bits0;
    logic [CNT_W_S-1:0] bits1;
`endif

    prbs8_checker #(.DATA_W(DATA_W), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .locked(locked0), .err_pulse(errp0), .loss_pulse(lossp0),
`ifdef PRBS8_CHK_BITCNT_EN
        .err_bits(bits0),
`endif
        .err_cnt(cnt0));

    prbs8_checker #(.DATA_W(DATA_W), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .locked(locked1), .err_pulse(errp1), .loss_pulse(lossp1),
`ifdef PRBS8_CHK_BITCNT_EN
        .err_bits(bits1),
`endif
        .err_cnt(cnt1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic logic [7:0] gstep(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model: collect bits until 8 are known, then track the predicted generator state.
    bit         m_locked;
    bit         m_q[$];
    logic [7:0] m_exp;
    int         m_miss;
    longint     m_errs, m_bits;
    bit         nx_err, nx_loss;

    bit     ex_locked, ex_err, ex_loss;
    longint ex_errs, ex_bits;

    task automatic model_reset();
        m_locked = 0; m_q.delete(); m_exp = '0; m_miss = 0;
        m_errs = 0; m_bits = 0; nx_err = 0; nx_loss = 0;
    endtask

    task automatic model_update(input bit v, input logic [DATA_W-1:0] d, input bit c);
        logic [7:0] seed;
        logic [DATA_W-1:0] diff;
        nx_err = 0;
        nx_loss = 0;
        if (v) begin
            if (!m_locked) begin
                m_q.push_back(d[0]);
                if (m_q.size() == 8) begin
                    seed = '0;
                    for (int i = 0; i < 8; i++) seed[i] = m_q[i];
                    m_q.delete();
                    if (seed != 0) begin
                        m_locked = 1;
                        m_exp = seed;
                        repeat (8) m_exp = gstep(m_exp);
                        m_miss = 0;
                    end
                end
            end else begin
                diff = d ^ m_exp[DATA_W-1:0];
                m_exp = gstep(m_exp);
                if (diff != 0) begin
                    nx_err = 1;
                    m_errs++;
                    m_bits += $countones(diff);
                    m_miss++;
                    if (m_miss == LOSS_THRESH) begin
                        nx_loss = 1;
                        m_locked = 0;
                        m_q.delete();
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin
            m_errs = 0;
            m_bits = 0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_locked <= 0; ex_err <= 0; ex_loss <= 0; ex_errs <= 0; ex_bits <= 0;
        end else begin
            ex_locked <= m_locked; ex_err <= nx_err; ex_loss <= nx_loss;
            ex_errs <= m_errs; ex_bits <= m_bits;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("locked",     locked0, ex_locked);
            chk("err_pulse",  errp0,   ex_err);
            chk("loss_pulse", lossp0,  ex_loss);
            chk("err_cnt",    cnt0,    sat(ex_errs, CNT_W));
            chk("s.locked",   locked1, ex_locked);
            chk("s.err_pulse", errp1,  ex_err);
            chk("s.loss_pulse", lossp1, ex_loss);
            chk("s.err_cnt",  cnt1,    sat(ex_errs, CNT_W_S));
`ifdef PRBS8_CHK_BITCNT_EN
            chk("err_bits",   bits0,   sat(ex_bits, CNT_W));
            chk("s.err_bits", bits1,   sat(ex_bits, CNT_W_S));
`endif
        end
    end

    logic [7:0] g;

    task automatic beat(input bit v, input logic [DATA_W-1:0] d, input bit c);
        @(negedge clk);
        #1;
        in_valid = v; in_data = d; clr = c;
        model_update(v, d, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            beat(1'b1, g[DATA_W-1:0], 1'b0);
            g = gstep(g);
        end
    endtask

    task automatic bad(input int n);
        for (int i = 0; i < n; i++) begin
            beat(1'b1, ~g[DATA_W-1:0], 1'b0);
            g = gstep(g);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1; in_valid = 0; clr = 0; in_data = '0;
        model_reset();
        #1;
        chk("rst.locked", locked0, 0);
        chk("rst.err_pulse", errp0, 0);
        chk("rst.loss_pulse", lossp0, 0);
        chk("rst.err_cnt", cnt0, 0);
        chk("rst.s.err_cnt", cnt1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        logic [7:0] s;
        logic [DATA_W-1:0] m;
        bit v, c;
        rst = 1; clr = 0; in_valid = 0; in_data = '0;
        model_reset();

        // Pin the generator model to the documented sequence 01,80,40,20,10,88,C4.
        s = 8'h01;
        s = gstep(s); chk("gen.step1", s, 8'h80);
        repeat (4) s = gstep(s); chk("gen.step5", s, 8'h88);
        s = gstep(s); chk("gen.step6", s, 8'hC4);

        #1;
        chk("init.locked", locked0, 0);
        chk("init.err_cnt", cnt0, 0);
        @(negedge clk); #1; rst = 0;
        chk_en = 1;

        // Clean stream from state 01: lock exactly after beat 8, no errors.
        g = 8'h01;
        clean(7); settle();
        chk("lock.beat7", locked0, 0);
        clean(1); settle();
        chk("lock.beat8", locked0, 1);
        clean(992); settle();
        chk("clean.err_cnt", cnt0, 0);

        // Single bit flip on in_data[1].
        beat(1'b1, g[DATA_W-1:0] ^ 2'b10, 1'b0); g = gstep(g); settle();
        chk("flip.err_pulse", errp0, 1);
        chk("flip.err_cnt", cnt0, 1);
        chk("flip.locked", locked0, 1);
        clean(20);

        // Clear, then a run of LOSS_THRESH bad beats drops lock; clean stream relocks after 8 beats.
        beat(1'b0, '0, 1'b1); settle();
        chk("clr.err_cnt", cnt0, 0);
        bad(LOSS_THRESH); settle();
        chk("loss.pulse", lossp0, 1);
        chk("loss.err_cnt", cnt0, 4);
        chk("loss.locked", locked0, 0);
        clean(7); settle();
        chk("relock.beat7", locked0, 0);
        clean(1); settle();
        chk("relock.beat8", locked0, 1);

        // All-zero input never locks.
        do_reset();
        for (int i = 0; i < 20; i++) beat(1'b1, '0, 1'b0);
        settle();
        chk("zero.locked", locked0, 0);
        chk("zero.err_cnt", cnt0, 0);

        // Random in_valid gaps on a clean stream.
        do_reset();
        g = 8'($urandom_range(1, 255));
        for (int i = 0; i < 300; i++) begin
            v = ($urandom % 2) == 1;
            beat(v, v ? g[DATA_W-1:0] : DATA_W'($urandom), 1'b0);
            if (v) g = gstep(g);
        end
        settle();
        chk("gaps.locked", locked0, 1);
        chk("gaps.err_cnt", cnt0, 0);

        // Drive the narrow counter into saturation without losing lock.
        beat(1'b0, '0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            bad(LOSS_THRESH - 1);
            clean(1);
        end
        settle();
        chk("sat.s.err_cnt", cnt1, 15);
        chk("sat.err_cnt", cnt0, 18);
        chk("sat.locked", locked0, 1);
        beat(1'b1, ~g[DATA_W-1:0], 1'b1); g = gstep(g); settle();
        chk("clrwin.err_pulse", errp0, 1);
        chk("clrwin.err_cnt", cnt0, 0);
        chk("clrwin.s.err_cnt", cnt1, 0);
        clean(4);

        // Random soak: gaps, sparse corruption, occasional clear and generator reseed.
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom % 4) != 0;
            c = ($urandom % 64) == 0;
            m = '0;
            if (($urandom % 12) == 0) m = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
            if (($urandom % 500) == 0) g = 8'($urandom_range(1, 255));
            beat(v, g[DATA_W-1:0] ^ m, c);
            if (v) g = gstep(g);
        end

        // Reset asserted while locked clears all outputs immediately.
        clean(12);
        bad(1);
        settle();
        chk("pre_rst.locked", locked0, 1);
        do_reset();
        clean(10);
        settle();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
